// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-ported memory, round-robin on conflict.
// Latency: grant is combinational in IDLE; read data/ack pulses MEM_LAT+1 cycles after grant.
// Backpressure: requesters hold req until gnt; no grants while an access is in flight (busy).
module mem_port_arbiter #(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  cnt;
    logic        last_owner;   // 0 = fetch, 1 = data
    logic        owner;        // port that owns the in-flight access
    logic        acc_we;       // in-flight access is a write (no read data capture)
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] if_rdata_q;
    logic [31:0] d_rdata_q;
    logic        if_rvalid_q;
    logic        d_rvalid_q;
    logic        grant_if;
    logic        grant_d;
    logic        done;

    // Next-state and grant decision; grants only from IDLE and never while reset is held.
    always_comb begin
        state_nxt = state;
        grant_if  = 1'b0;
        grant_d   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (!reset) begin
                    if (if_req && d_req) begin
                        // Conflict: whoever did not win last time goes now.
                        if (last_owner) grant_if = 1'b1;
                        else            grant_d  = 1'b1;
                    end else if (if_req) begin
                        grant_if = 1'b1;
                    end else if (d_req) begin
                        grant_d = 1'b1;
                    end
                end
                if (grant_if || grant_d) state_nxt = ACCESS;
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Ownership, latency counter and single-cycle write strobe.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= 4'd0;
            last_owner <= 1'b1;
            owner      <= 1'b0;
            acc_we     <= 1'b0;
            mem_we_q   <= 1'b0;
        end else begin
            mem_we_q <= 1'b0;
            if (grant_if || grant_d) begin
                owner      <= grant_d;
                last_owner <= grant_d;
                cnt        <= CNT_INIT;
                acc_we     <= grant_d & d_we;
                mem_we_q   <= grant_d & d_we;
            end else if (state == ACCESS && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
        end
    end

    // Address/write-data latch; held stable through ACCESS and afterwards until the next grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
        end else if (grant_if) begin
            mem_addr_q <= if_addr;
        end else if (grant_d) begin
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
        end
    end

    // Completion: pulse the owner's rvalid and capture read data (writes only acknowledge).
    always_ff @(posedge clk) begin
        if (reset) begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= 32'd0;
            d_rdata_q   <= 32'd0;
        end else begin
            if_rvalid_q <= done && !owner;
            d_rvalid_q  <= done && owner;
            if (done && !owner)          if_rdata_q <= mem_rdata;
            if (done && owner && !acc_we) d_rdata_q <= mem_rdata;
        end
    end

    assign if_gnt    = grant_if;
    assign d_gnt     = grant_d;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign busy      = (state == ACCESS);
    assign mem_en    = (state == ACCESS);
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule
